// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard and stall controller for the five-stage pipeline. A shadow scoreboard
// holds the destination register and remaining result latency (Tnew) of the
// instructions in E and M. Each cycle the D-stage operands are compared against
// it. A dependent instruction whose operand would be needed before the producer
// can forward it is held in D, and a bubble is injected into E.
//
// Optional feature: define MDU_STALL_EN to track the multiply/divide busy
// window and stall HI/LO consumers. Without it, md_busy is tied low and the
// md_* inputs are ignored.
//
// Handshake: there is no valid/ready pair. stall is an enable-low hold for PC
// and F/D. flush_E equals stall and turns the D/E register into a NOP on the
// same edge that the hold applies.

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic [4:0]  A3_D,
    input  logic [1:0]  Tnew_D,
    input  logic        md_start_D,
    input  logic        md_div_D,
    input  logic        md_use_D,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    // Scoreboard for the instructions currently in E and M.
    logic [4:0] a3_e;
    logic [1:0] tnew_e;
    logic [4:0] a3_m;
    logic [1:0] tnew_m;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;

    // Operand hazards. Register 0 is never a real dependency.
    always_comb begin
        hz_rs = (rs_D != 5'd0) &&
                (((rs_D == a3_e) && (tnew_e > Tuse_rs_D)) ||
                 ((rs_D == a3_m) && (tnew_m > Tuse_rs_D)));
        hz_rt = (rt_D != 5'd0) &&
                (((rt_D == a3_e) && (tnew_e > Tuse_rt_D)) ||
                 ((rt_D == a3_m) && (tnew_m > Tuse_rt_D)));
    end

`ifdef MDU_STALL_EN
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] md_cnt;

    // Busy counter. It loads only when the mult/div actually advances into E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_start_D && !stall) begin
            md_cnt <= md_div_D ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // HI/LO consumers wait while the unit is busy.
    always_comb begin
        md_busy = (md_cnt != '0);
        hz_md   = md_use_D && md_busy;
    end
`else
    // The MDU inputs and cycle parameters are deliberately left unconnected.
    localparam int UNUSED_CYCLES = MULT_CYCLES + DIV_CYCLES;
    logic unused_md;
    logic [31:0] unused_cycles;

    // No MDU tracking: never busy, never an HI/LO hazard.
    always_comb begin
        unused_md     = md_start_D ^ md_div_D ^ md_use_D;
        unused_cycles = UNUSED_CYCLES;
        md_busy       = 1'b0;
        hz_md         = 1'b0;
    end
`endif

    // Stall and bubble are the same condition.
    always_comb begin
        stall   = hz_rs | hz_rt | hz_md;
        flush_E = stall;
    end

    // Scoreboard shift. M always advances. E takes D, or a bubble when D is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3_e   <= 5'd0;
            tnew_e <= 2'd0;
            a3_m   <= 5'd0;
            tnew_m <= 2'd0;
        end else begin
            a3_m   <= a3_e;
            tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
            if (stall) begin
                a3_e   <= 5'd0;
                tnew_e <= 2'd0;
            end else begin
                a3_e   <= A3_D;
                tnew_e <= Tnew_D;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Drives producer/consumer instruction pairs through the D-stage inputs. For
// each cycle it queues the expected {stall, md_busy} and compares at the
// falling edge. The expectations for the mult/div cases depend on MDU_STALL_EN.

module tb_hazard_stall_ctrl;

`ifdef MDU_STALL_EN
    localparam logic MDU = 1'b1;
`else
    localparam logic MDU = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]  rs_D, rt_D, A3_D;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_D;
    logic        md_start_D, md_div_D, md_use_D;
    logic        stall, flush_E, md_busy;
    logic [31:0] stall_cnt;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D),
        .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
        .stall(stall), .flush_E(flush_E), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    // scoreboard
    logic [1:0]  exp_q[$];
    logic [31:0] exp_cnt;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver: one cycle of D-stage inputs, with the expected outputs for it
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                        input logic [4:0] a3, input logic [1:0] tn,
                        input logic ms, input logic md, input logic mu,
                        input logic es, input logic eb, input string tag);
        logic [1:0] e;
        rs_D = rs; rt_D = rt; Tuse_rs_D = tu_rs; Tuse_rt_D = tu_rt;
        A3_D = a3; Tnew_D = tn;
        md_start_D = ms; md_div_D = md; md_use_D = mu;
        exp_q.push_back({es, eb});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, e[1]});
        check({tag, ".flush_E"}, {31'd0, flush_E}, {31'd0, e[1]});
        check({tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, e[0]});
        check({tag, ".stall_cnt"}, stall_cnt, exp_cnt);
        if (e[1] && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic eb, input string tag);
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, eb, tag);
    endtask

    initial begin
        int n;
        int a3i;
        int rsi;
        int tni;
        int tui;
        reset = 1'b0; exp_cnt = 32'd0;
        rs_D = 5'd1; rt_D = 5'd1; Tuse_rs_D = 2'd0; Tuse_rt_D = 2'd0;
        A3_D = 5'd1; Tnew_D = 2'd2; md_start_D = 1'b1; md_div_D = 1'b0; md_use_D = 1'b1;
        #2;
        check("rst.stall", {31'd0, stall}, 32'd0);
        check("rst.flush_E", {31'd0, flush_E}, 32'd0);
        check("rst.md_busy", {31'd0, md_busy}, 32'd0);
        check("rst.stall_cnt", stall_cnt, 32'd0);
        #6 reset = 1'b1;
        @(posedge clk); #1;
        nop(1'b0, "idle0");
        nop(1'b0, "idle1");

        // lw $1 then dependent add: one stall cycle
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw1");
        step(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_hold");
        step(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add_go");
        check("lw_add.cnt", stall_cnt, 32'd1);
        nop(1'b0, "n0"); nop(1'b0, "n1");

        // lw $2 then beq: two stall cycles, Tnew_M = 1 in the second
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw2");
        step(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "beq_h1");
        check("beq.tnew_m", {30'd0, dut.tnew_m}, 32'd1);
        step(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "beq_h2");
        step(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "beq_go");
        nop(1'b0, "n2"); nop(1'b0, "n3");

        // ALU then beq on rt: one stall; ALU then ALU: none
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "alu9");
        step(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "beq9_h");
        step(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "beq9_go");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "alu10");
        step(5'd10, 5'd10, 2'd1, 2'd1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "alu_alu");
        // store data on rt after lw is not a hazard (Tuse 2)
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw7");
        step(5'd0, 5'd7, 2'd3, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sw7");
        nop(1'b0, "n4"); nop(1'b0, "n5");

        // writes to $0 never stall
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "prod0");
        step(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cons0");
        nop(1'b0, "n6");

        // mult then mflo
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "mult");
        for (int i = 0; i < 5; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1, MDU, MDU, "mflo_h");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mflo_go");
        nop(1'b0, "n7");

        // div then mflo
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "div");
        for (int i = 0; i < 10; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1, MDU, MDU, "mflo_dh");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mflo_dgo");
        nop(1'b0, "n8"); nop(1'b0, "n9");

        // random producer/consumer pairs: stall length is Tnew - Tuse on a match
        for (int it = 0; it < 30; it++) begin
            a3i = $urandom_range(1, 31);
            tni = $urandom_range(0, 2);
            tui = $urandom_range(0, 2);
            rsi = ($urandom_range(0, 1) == 1) ? a3i : (a3i % 31) + 1;
            n   = (rsi == a3i && tni > tui) ? tni - tui : 0;
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'(a3i), 2'(tni), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rnd_p");
            for (int k = 0; k < n; k++)
                step(5'(rsi), 5'd0, 2'(tui), 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rnd_h");
            step(5'(rsi), 5'd0, 2'(tui), 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rnd_go");
            nop(1'b0, "rnd_n0"); nop(1'b0, "rnd_n1");
        end

        // reset mid-stall with the div counter at 7 and a lw hazard pending
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "div_r");
        nop(MDU, "dr0"); nop(MDU, "dr1");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, MDU, "lw3");
        rs_D = 5'd3; rt_D = 5'd0; Tuse_rs_D = 2'd1; Tuse_rt_D = 2'd3;
        A3_D = 5'd0; Tnew_D = 2'd0; md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
        #4;
        check("pre_rst.stall", {31'd0, stall}, 32'd1);
        check("pre_rst.md_busy", {31'd0, md_busy}, {31'd0, MDU});
`ifdef MDU_STALL_EN
        check("pre_rst.md_cnt", 32'(dut.md_cnt), 32'd7);
`endif
        #1 reset = 1'b0;
        #1;
        check("mid_rst.stall", {31'd0, stall}, 32'd0);
        check("mid_rst.flush_E", {31'd0, flush_E}, 32'd0);
        check("mid_rst.md_busy", {31'd0, md_busy}, 32'd0);
        check("mid_rst.stall_cnt", stall_cnt, 32'd0);
        exp_cnt = 32'd0;
        #1 reset = 1'b1;
        #1;
        check("post_rst.sb", {22'd0, dut.a3_e, dut.tnew_e, dut.a3_m, dut.tnew_m}, 32'd0);
        check("post_rst.stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        nop(1'b0, "post0"); nop(1'b0, "post1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Hazard and stall controller for the five-stage pipeline. It owns a shadow scoreboard that mirrors the destination register and result-readiness of the instructions in E and M. From that scoreboard it decides each cycle whether the instruction in D must wait. When it must, the controller holds PC and F/D and injects a bubble into D/E, while E/M and M/W keep advancing. With the MDU option compiled in, it also tracks the multiply/divide unit's busy window and stalls HI/LO consumers.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E
- DIV_CYCLES, 10, busy cycles after div/divu enters E

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- Tuse_rs_D  in  2  cycles until rs is consumed (0 = branch/jr, 1 = ALU, 2 = store data; 3 = unused)
- Tuse_rt_D  in  2  same, for rt
- A3_D  in  5  destination register of instruction in D (0 = no write)
- Tnew_D  in  2  cycles from entering E until result is forwardable (lw = 2, ALU/lui/mf = 1, jal = 0)
- md_start_D  in  1  D holds mult/multu/div/divu
- md_div_D  in  1  qualifies md_start_D: 1 = divide
- md_use_D  in  1  D holds mfhi/mflo/mthi/mtlo/mult/div
- stall  out  1  hold PC and F/D (enable low)
- flush_E  out  1  clear D/E to NOP on next edge
- md_busy  out  1  MDU counter nonzero
- stall_cnt  out  32  saturating count of stalled cycles since reset

## Operation
- Scoreboard registers: A3_E, Tnew_E, A3_M, Tnew_M. All are zero after reset.
- hz_rs = (rs_D != 0) && ((rs_D == A3_E && Tnew_E > Tuse_rs_D) || (rs_D == A3_M && Tnew_M > Tuse_rs_D)). hz_rt is defined the same way for rt.
- hz_md = md_use_D && md_busy.
- stall = hz_rs | hz_rt | hz_md.
- flush_E = stall.
- Shift on every edge:
  - M stage: A3_M <= A3_E; Tnew_M <= (Tnew_E == 0) ? 0 : Tnew_E - 1. Decrement saturates, never wraps.
  - E stage, no stall: A3_E <= A3_D; Tnew_E <= Tnew_D.
  - E stage, stall: A3_E <= 0; Tnew_E <= 0. This is the bubble.
- A3 = 0 never matches, because the rs/rt != 0 guard excludes it.
- Match in both E and M: a stall is raised if either term holds.
- W stage is not tracked. A result in W is always forwardable, so it never causes a stall.
- MDU counter (4-bit minimum):
  - On an edge with md_start_D && !stall, load DIV_CYCLES if md_div_D, else MULT_CYCLES.
  - Otherwise decrement if nonzero.
  - md_busy = (count != 0).
- md_start_D under stall: no load. The instruction has not advanced.
- stall_cnt increments on each edge where stall = 1. It saturates at 32'hFFFFFFFF.

## Timing
- stall, flush_E and md_busy are combinational from current state and D-stage inputs. They are valid in the same cycle.
- All state updates on the rising clk edge. reset low clears state asynchronously, independent of clk.
- Outputs while reset is low: stall = 0, flush_E = 0, md_busy = 0, stall_cnt = 0.
- Reset asserted mid-stall or mid-MDU-busy: everything returns to the above values immediately, and no pending stall survives.
- Stall counts for a producer/consumer pair:
  - lw followed by a dependent ALU op: 1 stall cycle.
  - lw followed by a dependent beq/jr: 2 stall cycles.
  - ALU op followed by a dependent beq: 1 stall cycle.
  - ALU op followed by a dependent ALU op: 0 stall cycles.
- mult followed immediately by mflo: mflo stalls MULT_CYCLES cycles.
  - The counter is loaded with MULT_CYCLES on the edge that moves mult into E.
  - mflo advances on the edge after the counter reaches 0.

## Configuration
- MDU_STALL_EN defined:
  - MDU counter, hz_md and md_busy are implemented as described above.
- MDU_STALL_EN undefined:
  - Counter logic is compiled out and md_busy is tied to 0.
  - hz_md = 0.
  - md_start_D, md_div_D and md_use_D are ignored.
  - Parameters MULT_CYCLES and DIV_CYCLES stay declared but are unused.

## Test plan
- lw $1 (A3_D = 1, Tnew_D = 2), then add using rs = $1 with Tuse = 1 -> stall = flush_E = 1 for exactly 1 cycle, then 0; stall_cnt = 1.
- lw $2, then beq rs = $2 with Tuse = 0 -> stall high for 2 consecutive cycles; Tnew_M reads 1 in the second cycle.
- Producer with A3_D = 0, consumer rs = 0 -> stall never asserts.
- mult (md_start_D = 1, md_div_D = 0), then mflo (md_use_D = 1) -> md_busy high for 5 cycles, stall high for 5 cycles. Repeat with div -> 10 cycles.
- Assert reset low while the div counter = 7 and a lw hazard is pending -> md_busy, stall, flush_E and stall_cnt go to 0 without a clk edge. After release, scoreboard is empty.
- Compile without MDU_STALL_EN, mult then mflo -> stall = 0 and md_busy = 0 throughout.
